mem_responder: RTL and testbench

// - Word-addressed 16-bit memory target answering load/store/fetch requests from multi_cycle.
// - Request/acknowledge handshake with a programmable number of wait states.
// - Preload port lets a bench load machine code (e.g. 02a0, a281) before releasing the core.

---
 rtl/mem_responder.sv | 122 ++++++++++++
 tb/tb_mem_responder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed memory target with a req/ack handshake, programmable wait states
// and a preload port that is honoured only while idle.
module mem_responder #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  input  logic              pl_en,
  input  logic [ADDR_W-1:0] pl_addr,
  input  logic [DATA_W-1:0] pl_data
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [IDX_W-1:0]    idx, pl_idx;
  logic                in_range, access;

  assign idx      = addr_q[IDX_W-1:0];
  assign pl_idx   = pl_addr[IDX_W-1:0];
  assign in_range = ({1'b0, addr_q} < DEPTH_EXT);
  // The access happens on the edge that leaves WAIT, i.e. LATENCY+1 edges after accept.
  assign access   = (state_q == WAIT) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req) begin
        we_d    = we;
        addr_d  = addr;
        wdata_d = wdata;
        busy_d  = 1'b1;
        cnt_d   = 4'(LATENCY);
        state_d = WAIT;
      end
      WAIT: if (cnt_q == 4'd0) begin
        state_d = RESP;
        ack_d   = 1'b1;
        err_d   = !in_range;
        if (!we_q) rdata_d = in_range ? mem[idx] : '0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is never cleared; gating on state_q drops a pending write once reset hits.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && pl_en)
      mem[pl_idx] <= pl_data;
    else if (access && we_q && in_range)
      mem[idx] <= wdata_q;
  end

  assign ack   = ack_q;
  assign err   = err_q;
  assign busy  = busy_q;
  assign rdata = rdata_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at LATENCY=2, one at LATENCY=0.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        req, we, pl_en;
  logic [15:0] addr, wdata, pl_addr, pl_data;
  logic        ack, err, busy;
  logic [15:0] rdata;
  logic        r0_req, r0_we, r0_pl_en;
  logic [15:0] r0_addr, r0_wdata, r0_pl_addr, r0_pl_data;
  logic        r0_ack, r0_err, r0_busy;
  logic [15:0] r0_rdata;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .err(err), .busy(busy),
    .pl_en(pl_en), .pl_addr(pl_addr), .pl_data(pl_data));

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req(r0_req), .we(r0_we), .addr(r0_addr), .wdata(r0_wdata),
    .ack(r0_ack), .rdata(r0_rdata), .err(r0_err), .busy(r0_busy),
    .pl_en(r0_pl_en), .pl_addr(r0_pl_addr), .pl_data(r0_pl_data));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pl(input logic [15:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic pl0(input logic [15:0] a, input logic [15:0] d);
    r0_pl_en = 1'b1; r0_pl_addr = a; r0_pl_data = d;
    tick();
    r0_pl_en = 1'b0;
  endtask

  // LATENCY=2 transaction: accept at k, ack only after k+3, idle after k+4.
  task automatic txn(input string tag, input logic w, input logic [15:0] a, input logic [15:0] d,
                     input logic [15:0] exp_rd, input logic exp_err);
    req = 1'b1; we = w; addr = a; wdata = d;
    tick();
    chk({tag, "_busy_k"}, busy, 1);
    chk({tag, "_ack_k"}, ack, 0);
    req = 1'b0; addr = 16'hdead; wdata = 16'hbeef; we = ~w;
    tick();
    chk({tag, "_ack_k1"}, ack, 0);
    tick();
    chk({tag, "_ack_k2"}, ack, 0);
    tick();
    chk({tag, "_ack"}, ack, 1);
    chk({tag, "_rdata"}, rdata, exp_rd);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_busy_ack"}, busy, 1);
    tick();
    chk({tag, "_ack_end"}, ack, 0);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_err_end"}, err, 0);
  endtask

  // LATENCY=0 read: ack after k+1.
  task automatic txn0(input string tag, input logic [15:0] a, input logic [15:0] exp_rd);
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = a;
    tick();
    chk({tag, "_busy_k"}, r0_busy, 1);
    chk({tag, "_ack_k"}, r0_ack, 0);
    r0_req = 1'b0;
    tick();
    chk({tag, "_ack"}, r0_ack, 1);
    chk({tag, "_rdata"}, r0_rdata, exp_rd);
    tick();
    chk({tag, "_idle"}, r0_busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    req = 0; we = 0; addr = 0; wdata = 0; pl_en = 0; pl_addr = 0; pl_data = 0;
    r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0; r0_pl_en = 0; r0_pl_addr = 0; r0_pl_data = 0;
    #3;
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    tick();
    tick();
    reset = 1'b1;

    pl(16'h0000, 16'ha281);
    pl(16'h0003, 16'h1234);
    pl0(16'h0001, 16'ha454);
    pl0(16'h0002, 16'h1111);

    // preloaded read with LATENCY=2
    txn("t1", 1'b0, 16'h0000, 16'h0000, 16'ha281, 1'b0);
    // write leaves rdata untouched, then read returns the new value
    txn("t2w", 1'b1, 16'h0005, 16'h0df8, 16'ha281, 1'b0);
    txn("t2r", 1'b0, 16'h0005, 16'h0000, 16'h0df8, 1'b0);
    // out-of-range read/write, mem[0] intact
    txn("t3r", 1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1);
    txn("t3w", 1'b1, 16'h0100, 16'hffff, 16'h0000, 1'b1);
    txn("t3c", 1'b0, 16'h0000, 16'h0000, 16'ha281, 1'b0);

    // req held: accept every 5 edges, ack in the 4th cycle, busy low in the 5th
    req = 1'b1; we = 1'b0; addr = 16'h0005;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t4_ack_%0d", i), ack, ((i % 5) == 3) ? 1 : 0);
      chk($sformatf("t4_busy_%0d", i), busy, ((i % 5) == 4) ? 0 : 1);
    end
    req = 1'b0;

    // reset mid-WAIT aborts the write
    req = 1'b1; we = 1'b1; addr = 16'h0003; wdata = 16'h0ff8;
    tick();
    req = 1'b0;
    tick();
    chk("t5_busy_pre", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("t5_ack", ack, 0);
    chk("t5_busy", busy, 0);
    chk("t5_err", err, 0);
    chk("t5_rdata", rdata, 0);
    tick();
    tick();
    reset = 1'b1;
    txn("t5c", 1'b0, 16'h0003, 16'h0000, 16'h1234, 1'b0);

    // LATENCY=0: simultaneous preload and req of the same address
    r0_pl_en = 1'b1; r0_pl_addr = 16'h0007; r0_pl_data = 16'h7777;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 16'h0007;
    tick();
    r0_pl_en = 1'b0; r0_req = 1'b0;
    chk("t6s_busy", r0_busy, 1);
    tick();
    chk("t6s_ack", r0_ack, 1);
    chk("t6s_rdata", r0_rdata, 16'h7777);
    tick();

    // LATENCY=0 read with a preload attempted while busy
    r0_req = 1'b1; r0_addr = 16'h0001;
    tick();
    r0_req = 1'b0;
    chk("t6_busy", r0_busy, 1);
    chk("t6_ack_k", r0_ack, 0);
    r0_pl_en = 1'b1; r0_pl_addr = 16'h0002; r0_pl_data = 16'hbeef;
    tick();
    r0_pl_en = 1'b0;
    chk("t6_ack", r0_ack, 1);
    chk("t6_rdata", r0_rdata, 16'ha454);
    chk("t6_err", r0_err, 0);
    tick();
    chk("t6_idle", r0_busy, 0);
    txn0("t6c", 16'h0002, 16'h1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
